// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped branch target buffer for the fetch stage.
// Lookup is combinational over registered entries (no write-to-read bypass);
// training comes from the resolved control-transfer in ID, one per cycle.
// Optional feature macro: BTB_RAS_EN adds a circular return-address stack used
// to predict returns (jr $ra). Without it, update_call is ignored.
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 64,
    parameter int TAG_WIDTH  = 10,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [1:0]            update_kind,
    input  logic                  update_call,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_pred_taken,
    input  logic [ADDR_WIDTH-1:0] update_pred_target,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_addr
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 2 + TAG_WIDTH - 1;

    localparam logic [1:0] KIND_BRANCH = 2'd0;
    localparam logic [1:0] KIND_RETURN = 2'd3;

    // Entry storage; only the valid bits are cleared by reset.
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            kind_q   [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    // Next contents of the single entry addressed by update_pc.
    logic                  entry_wr_en;
    logic [TAG_WIDTH-1:0]  tag_d;
    logic [ADDR_WIDTH-1:0] target_d;
    logic [1:0]            kind_d;
    logic [1:0]            ctr_d;

    logic [IDX_W-1:0]      l_idx;
    logic [TAG_WIDTH-1:0]  l_tag;
    logic                  l_hit;
    logic [IDX_W-1:0]      u_idx;
    logic [TAG_WIDTH-1:0]  u_tag;
    logic                  u_hit;
    logic [ADDR_WIDTH-1:0] lookup_seq;
    logic                  ras_use;
    logic [ADDR_WIDTH-1:0] ras_top;

    assign l_idx      = lookup_pc[IDX_W+1:2];
    assign l_tag      = lookup_pc[TAG_HI:TAG_LO];
    assign l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_idx      = update_pc[IDX_W+1:2];
    assign u_tag      = update_pc[TAG_HI:TAG_LO];
    assign u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign lookup_seq = lookup_pc + ADDR_WIDTH'(4);

    // Prediction: taken only on a hit with a strongly/weakly-taken counter.
    always_comb begin
        predict_taken  = l_hit && ctr_q[l_idx][1];
        predict_target = lookup_seq;
        if (predict_taken) begin
            predict_target = ras_use ? ras_top : target_q[l_idx];
        end
    end

    // Misprediction detection and corrected fetch address for the ID outcome.
    always_comb begin
        mispredict    = update_valid &&
                        ((update_pred_taken != update_taken) ||
                         (update_taken && (update_pred_target != update_target)));
        redirect_addr = update_taken ? update_target : (update_pc + ADDR_WIDTH'(4));
    end

    // Training: hits adjust the counter/target, taken misses allocate.
    always_comb begin
        entry_wr_en = 1'b0;
        tag_d       = tag_q[u_idx];
        target_d    = target_q[u_idx];
        kind_d      = kind_q[u_idx];
        ctr_d       = ctr_q[u_idx];
        if (update_valid) begin
            if (u_hit) begin
                entry_wr_en = 1'b1;
                if (update_kind == KIND_BRANCH) begin
                    if (update_taken) begin
                        ctr_d    = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
                        target_d = update_target;
                    end else begin
                        ctr_d    = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
                    end
                end else begin
                    ctr_d    = 2'd3;
                    target_d = update_target;
                end
            end else if (update_taken) begin
                entry_wr_en = 1'b1;
                tag_d       = u_tag;
                target_d    = update_target;
                kind_d      = update_kind;
                ctr_d       = (update_kind == KIND_BRANCH) ? 2'd2 : 2'd3;
            end
        end
    end

    // Entry registers; reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (entry_wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= tag_d;
            target_q[u_idx] <= target_d;
            kind_q[u_idx]   <= kind_d;
            ctr_q[u_idx]    <= ctr_d;
        end
    end

`ifdef BTB_RAS_EN
    localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_W-1:0] RAS_LAST = RAS_W'(RAS_DEPTH - 1);
    localparam logic [RAS_W:0]   RAS_FULL = (RAS_W + 1)'(RAS_DEPTH);

    // ras_ptr_q points at the next free slot; the top is the slot before it.
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [RAS_W-1:0]      ras_ptr_q, ras_ptr_d;
    logic [RAS_W:0]        ras_cnt_q, ras_cnt_d;
    logic [RAS_W-1:0]      ras_top_idx;
    logic [RAS_W-1:0]      ras_next_idx;
    logic                  ras_wr_en;
    logic [RAS_W-1:0]      ras_wr_idx;
    logic                  do_pop;
    logic                  do_push;

    assign ras_top_idx  = (ras_ptr_q == '0) ? RAS_LAST : ras_ptr_q - RAS_W'(1);
    assign ras_next_idx = (ras_ptr_q == RAS_LAST) ? '0 : ras_ptr_q + RAS_W'(1);
    assign ras_top      = ras_q[ras_top_idx];
    assign ras_use      = (kind_q[l_idx] == KIND_RETURN) && (ras_cnt_q != '0);
    assign do_pop       = update_valid && (update_kind == KIND_RETURN) && (ras_cnt_q != '0);
    assign do_push      = update_valid && update_call;

    // Stack control: pop+push replaces the top; a full push overwrites the oldest.
    always_comb begin
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ras_ptr_q;
        if (do_pop && do_push) begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = ras_top_idx;
        end else if (do_pop) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end else if (do_push) begin
            ras_wr_en = 1'b1;
            ras_ptr_d = ras_next_idx;
            if (ras_cnt_q != RAS_FULL) begin
                ras_cnt_d = ras_cnt_q + 1'b1;
            end
        end
    end

    // Stack registers; the return address skips the delay slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_wr_en) begin
                ras_q[ras_wr_idx] <= update_pc + ADDR_WIDTH'(8);
            end
        end
    end
`else
    logic unused_ras_inputs;
    assign ras_use           = 1'b0;
    assign ras_top           = '0;
    assign unused_ras_inputs = ^{update_call, kind_q[l_idx]};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios followed by
// random traffic, checked against a table/queue model of the predictor.
module tb_branch_target_buffer;

    localparam int AW        = 32;
    localparam int ENTRIES   = 64;
    localparam int TAG_WIDTH = 10;
    localparam int RAS_DEPTH = 8;
    localparam int IDX_W     = $clog2(ENTRIES);
    localparam int EW        = 2 * AW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] lookup_pc = '0;
    logic          predict_taken;
    logic [AW-1:0] predict_target;
    logic          update_valid = 1'b0;
    logic [AW-1:0] update_pc = '0;
    logic [1:0]    update_kind = '0;
    logic          update_call = 1'b0;
    logic          update_taken = 1'b0;
    logic [AW-1:0] update_target = '0;
    logic          update_pred_taken = 1'b0;
    logic [AW-1:0] update_pred_target = '0;
    logic          mispredict;
    logic [AW-1:0] redirect_addr;

    branch_target_buffer #(
        .ADDR_WIDTH(AW), .ENTRIES(ENTRIES), .TAG_WIDTH(TAG_WIDTH), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_kind(update_kind),
        .update_call(update_call), .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .mispredict(mispredict), .redirect_addr(redirect_addr)
    );

    // Clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Expected record: {check_redirect, taken, target, mispredict, redirect}
    logic [EW-1:0] exp_q[$];

    // Reference model: a table keyed by index, and the return stack as a queue.
    bit            m_valid [ENTRIES];
    int unsigned   m_tag   [ENTRIES];
    logic [AW-1:0] m_tgt   [ENTRIES];
    int            m_kind  [ENTRIES];
    int            m_ctr   [ENTRIES];
    logic [AW-1:0] m_ras[$];

    function automatic int idx_of(input logic [AW-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [AW-1:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_WIDTH);
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic logic [AW:0] model_predict(input logic [AW-1:0] pc);
        logic [AW-1:0] seq;
        int i;
        seq = pc + 32'd4;
        i   = idx_of(pc);
        if (model_hit(pc) && m_ctr[i] >= 2) begin
`ifdef BTB_RAS_EN
            if (m_kind[i] == 3 && m_ras.size() > 0) return {1'b1, m_ras[m_ras.size()-1]};
`endif
            return {1'b1, m_tgt[i]};
        end
        return {1'b0, seq};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_update(input logic [AW-1:0] pc, input int kind, input bit call,
                                input bit tk, input logic [AW-1:0] tgt);
        int i;
        i = idx_of(pc);
        if (model_hit(pc)) begin
            if (kind == 0) begin
                if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else begin
                m_ctr[i] = 3;
                m_tgt[i] = tgt;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_kind[i]  = kind;
            m_ctr[i]   = (kind == 0) ? 2 : 3;
        end
`ifdef BTB_RAS_EN
        if (kind == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
        if (call) begin
            m_ras.push_back(pc + 32'd8);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
`else
        if (call) begin end
`endif
    endtask

    // Driver: one cycle of stimulus, expected response queued, model advanced.
    task automatic step(input bit r, input logic [AW-1:0] lpc, input bit uv,
                        input logic [AW-1:0] upc, input logic [1:0] kind, input bit call,
                        input bit tk, input logic [AW-1:0] tgt,
                        input bit ptk, input logic [AW-1:0] ptgt);
        logic [AW:0]   p;
        logic [AW-1:0] redir;
        bit            misp;
        @(posedge clk);
        #1;
        rst = r; lookup_pc = lpc; update_valid = uv; update_pc = upc;
        update_kind = kind; update_call = call; update_taken = tk;
        update_target = tgt; update_pred_taken = ptk; update_pred_target = ptgt;
        chk_en = !r;
        if (r) begin
            model_reset();
        end else begin
            p     = model_predict(lpc);
            misp  = uv && ((ptk != tk) || (tk && ptgt != tgt));
            redir = tk ? tgt : upc + 32'd4;
            exp_q.push_back({uv, p[AW], p[AW-1:0], misp, redir});
            if (uv) model_update(upc, int'(kind), call, tk, tgt);
        end
    endtask

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("predict_taken", AW'(predict_taken), AW'(e[2*AW+1]));
                check("predict_target", predict_target, e[2*AW:AW+1]);
                check("mispredict", AW'(mispredict), AW'(e[AW]));
                if (e[2*AW+2]) check("redirect_addr", redirect_addr, e[AW-1:0]);
            end
        end
    end

    function automatic logic [AW-1:0] rand_pc();
        logic [AW-1:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0040_0000;
            1:       base = 32'h0041_0000;
            default: base = 32'h0050_0000;
        endcase
        return base + 32'(($urandom_range(0, 15)) * 4) + 32'h100;
    endfunction

    initial begin
        logic [AW-1:0] upc, lpc, tgt, ptgt;
        logic [1:0]    kind;
        bit            call, tk, uv;

        // Reset, including a reset that coincides with an update.
        step(1, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 1, 32'h0040_0080, 0, 0);
        step(0, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0, 0);

        // Taken branch trains, then two not-taken, then saturation at zero.
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 1, 32'h0040_0080, 0, 32'h0040_0104);
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 0, 32'h0040_0080, 1, 32'h0040_0080);
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 0, 32'h0040_0080, 0, 32'h0040_0104);
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 0, 32'h0040_0080, 0, 32'h0040_0104);
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 1, 32'h0040_0080, 0, 32'h0040_0104);
        step(0, 32'h0040_0100, 1, 32'h0040_0100, 0, 0, 1, 32'h0040_0080, 0, 32'h0040_0104);
        step(0, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0, 0);

        // Aliasing: same index, different tag replaces the entry.
        step(0, 32'h0041_0100, 1, 32'h0041_0100, 1, 0, 1, 32'h0041_0400, 0, 32'h0041_0104);
        step(0, 32'h0041_0100, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0, 0);

        // Calls and returns (uses the stack when it is built in).
        step(0, 32'h0040_0300, 1, 32'h0040_0200, 1, 1, 1, 32'h0040_1000, 0, 32'h0040_0204);
        step(0, 32'h0040_0300, 1, 32'h0040_0300, 3, 0, 1, 32'h0040_0208, 0, 32'h0040_0304);
        step(0, 32'h0040_0300, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            upc = 32'h0040_0200 + 32'(i * 16);
            step(0, 32'h0040_0300, 1, upc, 1, 1, 1, 32'h0040_1000, 1, 32'h0040_1000);
        end
        for (int i = 0; i < 9; i++) begin
            tgt = 32'h0040_0208 + 32'((8 - i) * 16);
            step(0, 32'h0040_0300, 1, 32'h0040_0300, 3, 0, 1, tgt, 1, tgt);
        end
        step(0, 32'h0040_0300, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small aliasing pool.
        for (int n = 0; n < 800; n++) begin
            upc  = rand_pc();
            kind = 2'(((upc - 32'h100) / 4) % 4);
            call = (kind != 0) && ($urandom_range(0, 1) == 1);
            tk   = (kind != 0) || ($urandom_range(0, 1) == 1);
            tgt  = 32'h0040_0000 + 32'($urandom_range(0, 255) * 4);
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : upc + 32'd4;
            uv   = ($urandom_range(0, 3) != 0);
            lpc  = ($urandom_range(0, 2) == 0) ? upc : rand_pc();
            if ($urandom_range(0, 99) == 0) begin
                step(1, lpc, uv, upc, kind, call, tk, tgt, 1'($urandom_range(0, 1)), ptgt);
            end else begin
                step(0, lpc, uv, upc, kind, call, tk, tgt, 1'($urandom_range(0, 1)), ptgt);
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        update_valid = 1'b0;
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch/jump predictor for the fetch stage. It predicts direction and target for `lookup_pc` combinationally from registered state, so fetch can redirect without waiting for ID. It is trained by the resolved outcome from ID each cycle and flags mispredictions with the corrected fetch address. An optional return-address stack predicts `jr $ra` targets.

## Interface
- `ADDR_WIDTH`, 32, PC/target width.
- `ENTRIES`, 64, BTB entries; a power of two ≥ 2. `IDX_W = $clog2(ENTRIES)`.
- `TAG_WIDTH`, 10, stored tag bits. Requires `IDX_W + 2 + TAG_WIDTH <= ADDR_WIDTH`.
- `RAS_DEPTH`, 8, return-stack entries; a power of two. Only used with `BTB_RAS_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_pc`  in  ADDR_WIDTH  fetch PC.
- `predict_taken`  out  1  predicted redirect.
- `predict_target`  out  ADDR_WIDTH  predicted next PC: the target if taken, else `lookup_pc+4`.
- `update_valid`  in  1  ID presents a resolved control-transfer instruction.
- `update_pc`  in  ADDR_WIDTH  PC of the resolved instruction.
- `update_kind`  in  2  0 = conditional branch, 1 = direct jump (j/jal), 2 = indirect (jr/jalr, not return), 3 = return (`jr $ra`).
- `update_call`  in  1  instruction writes a link register (jal/jalr).
- `update_taken`  in  1  resolved direction.
- `update_target`  in  ADDR_WIDTH  resolved taken target.
- `update_pred_taken`, `update_pred_target`  in  1, ADDR_WIDTH  prediction carried down the pipe with this instruction.
- `mispredict`  out  1  prediction was wrong; fetch must flush.
- `redirect_addr`  out  ADDR_WIDTH  correct next PC: `update_target` if taken, else `update_pc+4`.

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[IDX_W+2+TAG_WIDTH-1:IDX_W+2]`. Each entry holds valid, tag, target, kind, and a 2-bit saturating counter.
- Lookup hit requires valid and tag match. `predict_taken = hit & ctr[1]`.
- Lookup miss or not-taken: `predict_taken=0`, `predict_target=lookup_pc+4`. All adds are modulo 2^ADDR_WIDTH.
- Update when `update_valid` is high:
  - Hit, conditional branch: counter increments when taken, decrements when not, saturating at 0 and 3. Target is overwritten only when taken.
  - Hit, kinds 1–3: counter is forced to 3 and target is overwritten.
  - Miss and taken: the entry is allocated and overwrites any old entry. Sets valid and tag, target = `update_target`, kind = `update_kind`. Counter = 2 for conditional branches, 3 otherwise.
  - Miss and not taken: no write.
- `mispredict = update_valid & ((update_pred_taken != update_taken) | (update_taken & update_pred_target != update_target))`. It is combinational and is 0 when `update_valid=0`.
- Reset:
  - All valid bits clear in one cycle.
  - Outputs then read `predict_taken=0`, `predict_target=lookup_pc+4`, `mispredict=0`.
  - `rst` has priority over a concurrent update.

## Timing
- Lookup is purely combinational over registered state: zero-cycle latency.
- An update written at edge N is visible to lookup from cycle N+1. There is no write-to-read bypass: a same-cycle lookup of the index being updated returns the old contents.
- `mispredict` and `redirect_addr` are valid in the same cycle as `update_valid`.
- Only one update per cycle. No handshake; ID guarantees `update_valid` only for control-transfer instructions.

## Configuration
- `BTB_RAS_EN` defined: adds a circular return-address stack (pointer plus a count saturating at RAS_DEPTH).
  - Update with `update_call`: pushes `update_pc+8`, which skips the delay slot.
  - Update with kind 3: pops.
  - Both on the same update: pop then push, so the top is replaced and the count is unchanged.
  - Push when full: overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Pop when empty: no-op.
  - Lookup hit with stored kind 3, taken, and a non-empty RAS: `predict_target` = RAS top instead of the BTB target.
  - Reset clears the count and pointer.
- Undefined: no RAS logic. `update_call` is ignored and kind 3 uses the BTB target.

## Test plan
- Reset, then lookup 0x0040_0100 → `predict_taken=0`, `predict_target=0x0040_0104`.
- Taken beq at 0x0040_0100 → 0x0040_0080 with prediction 0 → `mispredict=1`, `redirect_addr=0x0040_0080`. Next cycle, lookup 0x0040_0100 → taken, 0x0040_0080 (counter 2).
- Same branch resolves not-taken twice → counter 2→1→0; lookup then predicts not-taken, target 0x0040_0104. Counter saturates at 0 on a third not-taken.
- Aliasing with ENTRIES=64: 0x0040_0100 vs 0x0041_0100 (same index, different tag) → the second lookup misses until it is allocated, after which the first misses.
- Update and lookup of the same index in the same cycle → old prediction this cycle, new one next cycle. `rst` asserted with `update_valid` → no entry written.
- `BTB_RAS_EN`: jal at 0x0040_0200, then `jr $ra` resolved (kind 3) at 0x0040_0300 → lookup of 0x0040_0300 predicts 0x0040_0208. Nine calls with RAS_DEPTH=8 then nine returns → the first eight pops are correct and the ninth returns the BTB target.
